read_reorder_buffer: RTL and testbench

READ_REORDER_BUFFER -- requirements
Module: read_reorder_buffer

---
 rtl/dram_cache_pkg.sv | 21 ++
 rtl/rob_entry_ram.sv | 26 ++
 rtl/read_reorder_buffer.sv | 145 ++++++++++++++
 tb/tb_read_reorder_buffer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_cache_pkg.sv
// Shared widths and field layout for the DRAM-cache read path.
// Field offsets are measured from the top of the data field, so they hold for any DATA_W.
package dram_cache_pkg;

    localparam int DATA_W    = 512;
    localparam int ROB_DEPTH = 16;
    localparam int SEQ_W     = 4;
    localparam int ID_W      = 4;
    localparam int RESP_W    = 2;

    // Fill write word: {resp, seq, rid, data}
    localparam int WR_RID_OFS  = 0;
    localparam int WR_SEQ_OFS  = ID_W;
    localparam int WR_RESP_OFS = ID_W + SEQ_W;

    // Stored entry: {resp, rid, data}
    localparam int ENT_RID_OFS  = 0;
    localparam int ENT_RESP_OFS = ID_W;
    localparam int ENT_META_W   = ID_W + RESP_W;

endpackage

// File: rtl/rob_entry_ram.sv
// Reorder-buffer payload storage: one synchronous write port and one
// combinational read port, so the head entry can be loaded into the R register with no extra cycle.
module rob_entry_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 518
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/read_reorder_buffer.sv
// Read reorder buffer: slots are allocated in AR order, filled out of order,
// and retired in allocation order through a single registered AXI R stage.
module read_reorder_buffer
    import dram_cache_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int DATA_W = dram_cache_pkg::DATA_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                alloc_req_i,
    output logic                                alloc_gnt_o,
    output logic [SEQ_W-1:0]                    alloc_seq_o,
    input  logic                                write_en_i,
    output logic                                full_o,
    input  logic [RESP_W+SEQ_W+ID_W+DATA_W-1:0] wdata_i,
    output logic                                rvalid_o,
    input  logic                                rready_i,
    output logic [DATA_W-1:0]                   rdata_o,
    output logic [ID_W-1:0]                     rid_o,
    output logic [RESP_W-1:0]                   rresp_o,
    output logic                                rlast_o,
    output logic                                err_o
);

    localparam int ENT_W = ENT_META_W + DATA_W;
    localparam logic [SEQ_W:0]   DEPTH_CNT = (SEQ_W+1)'(DEPTH);
    localparam logic [SEQ_W:0]   CNT_ONE   = (SEQ_W+1)'(1);
    localparam logic [SEQ_W-1:0] PTR_ONE   = SEQ_W'(1);

    logic [SEQ_W-1:0]  head_reg, tail_reg;
    logic [SEQ_W:0]    count_reg, count_next;
    logic [DEPTH-1:0]  alloc_bits_reg, alloc_bits_next;
    logic [DEPTH-1:0]  filled_bits_reg, filled_bits_next;
    logic              full_reg, rst_dly_reg, err_reg;
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [ID_W-1:0]   rid_reg;
    logic [RESP_W-1:0] rresp_reg;

    logic              alloc_gnt, wr_fire, wr_ok, wr_bad, load;
    logic [SEQ_W-1:0]  wr_seq;
    logic [ID_W-1:0]   wr_rid;
    logic [RESP_W-1:0] wr_resp;
    logic [DATA_W-1:0] wr_data;
    logic [ENT_W-1:0]  ram_rdata;

    assign wr_data = wdata_i[DATA_W-1:0];
    assign wr_rid  = wdata_i[DATA_W+WR_RID_OFS  +: ID_W];
    assign wr_seq  = wdata_i[DATA_W+WR_SEQ_OFS  +: SEQ_W];
    assign wr_resp = wdata_i[DATA_W+WR_RESP_OFS +: RESP_W];

    always_comb begin
        alloc_gnt = alloc_req_i && (count_reg < DEPTH_CNT);
        wr_fire   = write_en_i && !full_reg;
        // A fill is only legal into a slot that is allocated and still empty
        wr_ok     = wr_fire && alloc_bits_reg[wr_seq] && !filled_bits_reg[wr_seq];
        wr_bad    = wr_fire && !(alloc_bits_reg[wr_seq] && !filled_bits_reg[wr_seq]);
        load      = filled_bits_reg[head_reg] && (!rvalid_reg || rready_i);
        count_next = count_reg;
        case ({alloc_gnt, load})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Per-slot bitmap update; allocate/free never hit the same slot because
    // a grant requires a free slot while a free targets an occupied head.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            localparam logic [SEQ_W-1:0] IDX = SEQ_W'(gi);
            assign alloc_bits_next[gi] =
                (alloc_gnt && tail_reg == IDX) ? 1'b1 :
                (load && head_reg == IDX)      ? 1'b0 : alloc_bits_reg[gi];
            assign filled_bits_next[gi] =
                (wr_ok && wr_seq == IDX)  ? 1'b1 :
                (load && head_reg == IDX) ? 1'b0 : filled_bits_reg[gi];
        end
    endgenerate

    rob_entry_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (SEQ_W),
        .WIDTH  (ENT_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_seq),
        .wdata ({wr_resp, wr_rid, wr_data}),
        .raddr (head_reg),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
            alloc_bits_reg  <= '0;
            filled_bits_reg <= '0;
            err_reg         <= 1'b0;
            full_reg        <= 1'b1;
            rst_dly_reg     <= 1'b1;
            rvalid_reg      <= 1'b0;
            rdata_reg       <= '0;
            rid_reg         <= '0;
            rresp_reg       <= '0;
        end else begin
            if (alloc_gnt) begin
                tail_reg <= tail_reg + PTR_ONE;
            end
            if (load) begin
                head_reg <= head_reg + PTR_ONE;
            end
            count_reg       <= count_next;
            alloc_bits_reg  <= alloc_bits_next;
            filled_bits_reg <= filled_bits_next;
            err_reg         <= err_reg | wr_bad;
            // Writers stay blocked for one full cycle after reset release
            full_reg        <= rst_dly_reg;
            rst_dly_reg     <= 1'b0;
            if (load) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= ram_rdata[DATA_W-1:0];
                rid_reg    <= ram_rdata[DATA_W+ENT_RID_OFS  +: ID_W];
                rresp_reg  <= ram_rdata[DATA_W+ENT_RESP_OFS +: RESP_W];
            end else if (rready_i) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    assign alloc_gnt_o = alloc_gnt;
    assign alloc_seq_o = tail_reg;
    assign full_o      = full_reg;
    assign err_o       = err_reg;
    assign rvalid_o    = rvalid_reg;
    assign rdata_o     = rdata_reg;
    assign rid_o       = rid_reg;
    assign rresp_o     = rresp_reg;
    assign rlast_o     = rvalid_reg;

endmodule

// File: tb/tb_read_reorder_buffer.sv
// Self-checking bench for read_reorder_buffer: table-driven fill vectors plus
// hand-written capacity, backpressure, error and reset sequences, all scored against an expected-beat queue.
module tb_read_reorder_buffer;
    import dram_cache_pkg::*;

    localparam int DW = 512;
    localparam int WW = RESP_W + SEQ_W + ID_W + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_req_i = 1'b0;
    logic          alloc_gnt_o;
    logic [3:0]    alloc_seq_o;
    logic          write_en_i = 1'b0;
    logic          full_o;
    logic [WW-1:0] wdata_i = '0;
    logic          rvalid_o;
    logic          rready_i = 1'b0;
    logic [DW-1:0] rdata_o;
    logic [3:0]    rid_o;
    logic [1:0]    rresp_o;
    logic          rlast_o;
    logic          err_o;

    read_reorder_buffer #(.DEPTH(16), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req_i (alloc_req_i),
        .alloc_gnt_o (alloc_gnt_o),
        .alloc_seq_o (alloc_seq_o),
        .write_en_i  (write_en_i),
        .full_o      (full_o),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rready_i    (rready_i),
        .rdata_o     (rdata_o),
        .rid_o       (rid_o),
        .rresp_o     (rresp_o),
        .rlast_o     (rlast_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    seq;
        logic [3:0]    rid;
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } vec_t;

    typedef struct {
        logic [3:0]    rid;
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } beat_t;

    vec_t  vecs [5];
    beat_t exp_q [$];
    int    checks = 0;
    int    errors = 0;
    int    beats  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every R handshake must match the oldest outstanding expectation
    always @(negedge clk) begin
        beat_t e;
        if (!rst && rvalid_o && rready_i) begin
            beats++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got rid %0d data %0h, expected no beat", rid_o, rdata_o);
            end else begin
                e = exp_q.pop_front();
                $display("beat %0d: rid=%0d resp=%0d data=%0h", beats, rid_o, rresp_o, rdata_o);
                chk_data("beat_data", rdata_o, e.data);
                chk("beat_rid", int'(rid_o), int'(e.rid));
                chk("beat_resp", int'(rresp_o), int'(e.resp));
                chk("beat_rlast", int'(rlast_o), 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(output logic gnt, output logic [3:0] seq);
        alloc_req_i = 1'b1;
        #1;
        gnt = alloc_gnt_o;
        seq = alloc_seq_o;
        tick();
        alloc_req_i = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] seq, input logic [3:0] rid,
                            input logic [1:0] resp, input logic [DW-1:0] data);
        write_en_i = 1'b1;
        wdata_i    = {resp, seq, rid, data};
        tick();
        write_en_i = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        rst         = 1'b1;
        alloc_req_i = 1'b0;
        write_en_i  = 1'b0;
        rready_i    = 1'b0;
        repeat (cycles) tick();
        chk("rst_rvalid", int'(rvalid_o), 0);
        chk("rst_full", int'(full_o), 1);
        chk("rst_err", int'(err_o), 0);
        chk("rst_rlast", int'(rlast_o), 0);
        chk("rst_rid", int'(rid_o), 0);
        chk("rst_rresp", int'(rresp_o), 0);
        chk_data("rst_rdata", rdata_o, '0);
        rst = 1'b0;
        exp_q.delete();
        tick();
        chk("full_after_rst_1", int'(full_o), 1);
        tick();
        chk("full_after_rst_2", int'(full_o), 0);
    endtask

    task automatic wait_drain(input int target);
        for (int c = 0; c < 40 && !(beats >= target && exp_q.size() == 0); c++) tick();
        chk("drain_beats", beats, target);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    task automatic run_vectors(input int first, input int n, input bit ooo);
        logic       g;
        logic [3:0] s;
        int         b0;
        rready_i = 1'b1;
        b0 = beats;
        for (int i = 0; i < n; i++) begin
            do_alloc(g, s);
            chk("alloc_gnt", int'(g), 1);
            chk("alloc_seq", int'(s), i);
            for (int k = first; k < first + n; k++)
                if (int'(vecs[k].seq) == i)
                    exp_q.push_back('{vecs[k].rid, vecs[k].resp, vecs[k].data});
        end
        for (int k = first; k < first + n; k++) begin
            if (ooo && vecs[k].seq != 4'd0) chk("no_early_rvalid", int'(rvalid_o), 0);
            do_write(vecs[k].seq, vecs[k].rid, vecs[k].resp, vecs[k].data);
        end
        if (ooo) begin
            for (int c = 0; c < n; c++) begin
                tick();
                chk("stream_rvalid", int'(rvalid_o), 1);
            end
        end
        wait_drain(b0 + n);
    endtask

    initial begin : main
        logic          g;
        logic [3:0]    s;
        int            b0;
        logic [DW-1:0] d [4];

        vecs[0] = '{4'd0, 4'd3, 2'd0, DW'('hab)};
        vecs[1] = '{4'd1, 4'd5, 2'd0, DW'('hcd)};
        vecs[2] = '{4'd2, 4'd2, 2'd1, DW'('h22)};
        vecs[3] = '{4'd1, 4'd1, 2'd2, DW'('h11)};
        vecs[4] = '{4'd0, 4'd0, 2'd3, DW'('h00)};

        apply_reset(3);

        // In-order fills, then out-of-order fills that must retire in order
        run_vectors(0, 2, 1'b0);
        apply_reset(2);
        run_vectors(2, 3, 1'b1);

        // Capacity and pointer wrap
        apply_reset(2);
        rready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            do_alloc(g, s);
            chk("cap_gnt", int'(g), 1);
            chk("cap_seq", int'(s), i);
        end
        do_alloc(g, s);
        chk("cap_17th_gnt", int'(g), 0);
        b0 = beats;
        exp_q.push_back('{4'd9, 2'd0, DW'('h5150)});
        do_write(4'd0, 4'd9, 2'd0, DW'('h5150));
        wait_drain(b0 + 1);
        do_alloc(g, s);
        chk("wrap_gnt", int'(g), 1);
        chk("wrap_seq", int'(s), 0);
        do_alloc(g, s);
        chk("refull_gnt", int'(g), 0);

        // Backpressure: three wide beats held under rready=0
        apply_reset(2);
        b0 = beats;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < DW / 32; j++) d[i][j*32 +: 32] = $urandom();
            do_alloc(g, s);
            chk("bp_seq", int'(s), i);
            exp_q.push_back('{4'(i + 1), 2'(i), d[i]});
        end
        for (int i = 0; i < 3; i++) do_write(4'(i), 4'(i + 1), 2'(i), d[i]);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_rvalid_held", int'(rvalid_o), 1);
            chk_data("bp_rdata_stable", rdata_o, d[0]);
        end
        rready_i = 1'b1;
        wait_drain(b0 + 3);

        // Protocol errors: unallocated slot and refill of a filled slot
        apply_reset(2);
        rready_i = 1'b1;
        b0 = beats;
        do_alloc(g, s);
        do_write(4'd7, 4'd1, 2'd0, DW'('h77));
        chk("err_unalloc", int'(err_o), 1);
        repeat (3) tick();
        chk("err_no_rvalid", int'(rvalid_o), 0);
        chk("err_no_beat", beats, b0);
        exp_q.push_back('{4'd6, 2'd0, DW'('h5a)});
        do_write(4'd0, 4'd6, 2'd0, DW'('h5a));
        do_write(4'd0, 4'd8, 2'd1, DW'('h99));
        wait_drain(b0 + 1);
        chk("err_sticky", int'(err_o), 1);

        // Reset in the middle of a stream
        apply_reset(2);
        for (int i = 0; i < 4; i++) begin
            do_alloc(g, s);
            exp_q.push_back('{4'(i), 2'd0, DW'(i + 'h40)});
        end
        for (int i = 0; i < 4; i++) do_write(4'(i), 4'(i), 2'd0, DW'(i + 'h40));
        tick();
        chk("mid_pre_rst_rvalid", int'(rvalid_o), 1);
        b0 = beats;
        apply_reset(1);
        rready_i = 1'b1;
        repeat (5) tick();
        chk("mid_no_beat", beats, b0);
        do_alloc(g, s);
        chk("mid_gnt", int'(g), 1);
        chk("mid_seq", int'(s), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
